usb_recv_core: RTL

- Parametrised USB receive front-end for the usbhost subsystem; generalises the low-speed receiver to low-speed or full-speed operation with configurable oversampling.
- Synchronises D+/D-, recovers bit timing, detects SYNC, decodes NRZI, removes stuffed bits and delivers bytes.
- Reports packet status at EOP: PID check, CRC5/CRC16 residual check, stuff error, partial byte.
- Feeds the host packet engine, which consumes bytes and the end-of-packet status pulse.

---
 rtl/usb_recv_core.sv | 257 +++++++++++++++++++++++++
 1 files changed

// File: rtl/usb_recv_core.sv
// USB receive front-end: line sync, bit recovery, SYNC/NRZI/unstuff, byte and EOP status.
// clk/reset_n, dp/dm raw line, enable; rx_active, se0, rdata/rdata_valid, rbyte_cnt, rx_done + status.
module usb_recv_core #(
  parameter bit LOW_SPEED  = 1'b1,
  parameter int OVERSAMPLE = 8,
  parameter int CNT_W      = 11
) (
  input  logic             clk,
  input  logic             reset_n,
  input  logic             dp,
  input  logic             dm,
  input  logic             enable,
  output logic             rx_active,
  output logic             se0,
  output logic [7:0]       rdata,
  output logic             rdata_valid,
  output logic [CNT_W-1:0] rbyte_cnt,
  output logic             rx_done,
  output logic             pid_ok,
  output logic             crc5_ok,
  output logic             crc16_ok,
  output logic             stuff_err,
  output logic             dribble
);

  typedef enum logic [1:0] {
    IDLE,
    SYNC,
    DATA,
    EOP_WAIT
  } state_e;

  localparam int BW = $clog2(OVERSAMPLE);
  localparam logic [BW-1:0] STB = BW'(OVERSAMPLE/2-1);
  localparam logic [BW-1:0] TOP = BW'(OVERSAMPLE-1);
  // Sync flops reset to the idle J level so se0 reads 0 in reset.
  localparam logic JDP = ~LOW_SPEED;

  logic dp_q1, dp_q2, dm_q1, dm_q2;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      dp_q1 <= JDP;
      dp_q2 <= JDP;
      dm_q1 <= ~JDP;
      dm_q2 <= ~JDP;
    end else begin
      dp_q1 <= dp;
      dp_q2 <= dp_q1;
      dm_q1 <= dm;
      dm_q2 <= dm_q1;
    end
  end

  assign se0 = ~(dp_q1 | dm_q1 | dp_q2 | dm_q2);

  logic jn, live, chg, stb, nb;
  state_e state_q, state_d;
  logic [BW-1:0] bc_q, bc_d, idc_q, idc_d;
  logic jl_q, jl_d, pj_q, pj_d;
  logic [2:0] ones_q, ones_d, bitc_q, bitc_d;
  logic [1:0] zc_q, zc_d;
  logic [7:0] sh_q, sh_d, nsh, rdata_q, rdata_d;
  logic [4:0] crc5_q, crc5_d, c5n;
  logic [15:0] crc16_q, crc16_d, c16n;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic vld_q, vld_d, done_q, done_d, act_q, act_d;
  logic pid_q, pid_d, c5_q, c5_d, c16_q, c16_d;
  logic se_q, se_d, dr_q, dr_d;

  // j is only meaningful once the second stage has left SE0,
  // which hides the one-cycle fake K an FS line shows after EOP.
  assign jn   = LOW_SPEED ? ~dp_q2 : dp_q2;
  assign live = (dp_q2 | dm_q2) & ~se0;
  assign chg  = live & (jn != jl_q);
  assign stb  = live & ~chg & (bc_q == STB);
  assign nb   = (jn == pj_q);
  assign nsh  = {nb, sh_q[7:1]};
  assign c5n  = {crc5_q[3:0], 1'b0}
              ^ ({5{crc5_q[4] ^ nb}} & 5'h05);
  assign c16n = {crc16_q[14:0], 1'b0}
              ^ ({16{crc16_q[15] ^ nb}} & 16'h8005);

  assign bc_d = (se0 | chg | (bc_q == TOP))
              ? '0 : bc_q + BW'(1);
  assign jl_d = live ? jn : jl_q;

  always_comb begin
    state_d = state_q;
    idc_d   = '0;
    pj_d    = pj_q;
    ones_d  = ones_q;
    bitc_d  = bitc_q;
    zc_d    = zc_q;
    sh_d    = sh_q;
    rdata_d = rdata_q;
    crc5_d  = crc5_q;
    crc16_d = crc16_q;
    cnt_d   = cnt_q;
    vld_d   = 1'b0;
    done_d  = 1'b0;
    act_d   = act_q;
    pid_d   = pid_q;
    c5_d    = c5_q;
    c16_d   = c16_q;
    se_d    = se_q;
    dr_d    = dr_q;
    unique case (state_q)
      IDLE: begin
        // chg with jn = 0 is exactly a J->K edge.
        if (enable && chg && !jn) begin
          state_d = SYNC;
          pj_d    = 1'b1;
          ones_d  = '0;
          zc_d    = '0;
          bitc_d  = '0;
          sh_d    = '0;
          crc5_d  = 5'h1F;
          crc16_d = 16'hFFFF;
          cnt_d   = '0;
          pid_d   = 1'b0;
          c5_d    = 1'b0;
          c16_d   = 1'b0;
          se_d    = 1'b0;
          dr_d    = 1'b0;
        end
      end
      SYNC: begin
        if (se0) begin
          state_d = IDLE;
        end else if (stb) begin
          pj_d = jn;
          if (nb) begin
            ones_d  = ones_q + 3'd1;
            state_d = (zc_q == 2'd3) ? DATA : IDLE;
            act_d   = (zc_q == 2'd3);
          end else begin
            ones_d = '0;
            zc_d   = (zc_q == 2'd3) ? zc_q : zc_q + 2'd1;
          end
        end
      end
      DATA: begin
        if (se0) begin
          state_d = EOP_WAIT;
          done_d  = 1'b1;
          act_d   = 1'b0;
          c5_d    = (crc5_q == 5'h0C);
          c16_d   = (crc16_q == 16'h800D);
          dr_d    = (bitc_q != 3'd0);
        end else if (stb) begin
          pj_d = jn;
          if (ones_q == 3'd6) begin
            if (nb) begin
              state_d = EOP_WAIT;
              done_d  = 1'b1;
              act_d   = 1'b0;
              se_d    = 1'b1;
              c5_d    = 1'b0;
              c16_d   = 1'b0;
              dr_d    = 1'b0;
            end else begin
              ones_d = '0;
            end
          end else begin
            ones_d = nb ? ones_q + 3'd1 : 3'd0;
            sh_d   = nsh;
            bitc_d = bitc_q + 3'd1;
            // The PID byte is excluded from both CRCs.
            if (cnt_q != '0) begin
              crc5_d  = c5n;
              crc16_d = c16n;
            end
            if (bitc_q == 3'd7) begin
              rdata_d = nsh;
              vld_d   = 1'b1;
              cnt_d   = (cnt_q == '1) ? cnt_q
                      : cnt_q + CNT_W'(1);
              if (cnt_q == '0)
                pid_d = (nsh[3:0] == ~nsh[7:4]);
            end
          end
        end
      end
      EOP_WAIT: begin
        if (live && jn) begin
          idc_d = idc_q + BW'(1);
          if (idc_q == TOP) begin
            state_d = IDLE;
            idc_d   = '0;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= IDLE;
      bc_q    <= '0;
      idc_q   <= '0;
      jl_q    <= 1'b1;
      pj_q    <= 1'b1;
      ones_q  <= '0;
      bitc_q  <= '0;
      zc_q    <= '0;
      sh_q    <= '0;
      rdata_q <= '0;
      crc5_q  <= 5'h1F;
      crc16_q <= 16'hFFFF;
      cnt_q   <= '0;
      vld_q   <= 1'b0;
      done_q  <= 1'b0;
      act_q   <= 1'b0;
      pid_q   <= 1'b0;
      c5_q    <= 1'b0;
      c16_q   <= 1'b0;
      se_q    <= 1'b0;
      dr_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      bc_q    <= bc_d;
      idc_q   <= idc_d;
      jl_q    <= jl_d;
      pj_q    <= pj_d;
      ones_q  <= ones_d;
      bitc_q  <= bitc_d;
      zc_q    <= zc_d;
      sh_q    <= sh_d;
      rdata_q <= rdata_d;
      crc5_q  <= crc5_d;
      crc16_q <= crc16_d;
      cnt_q   <= cnt_d;
      vld_q   <= vld_d;
      done_q  <= done_d;
      act_q   <= act_d;
      pid_q   <= pid_d;
      c5_q    <= c5_d;
      c16_q   <= c16_d;
      se_q    <= se_d;
      dr_q    <= dr_d;
    end
  end

  assign rx_active   = act_q;
  assign rdata       = rdata_q;
  assign rdata_valid = vld_q;
  assign rbyte_cnt   = cnt_q;
  assign rx_done     = done_q;
  assign pid_ok      = pid_q;
  assign crc5_ok     = c5_q;
  assign crc16_ok    = c16_q;
  assign stuff_err   = se_q;
  assign dribble     = dr_q;

endmodule
